wrr_sp_arbiter: RTL and testbench

- Sequential write-port arbiter for the SRAM controller write path.
- Selects one of num_of_ports ingress ports requesting a packet write, using one of two modes:
  - strict priority (SP);
  - weighted round robin (WRR), where the weight is derived from each port's 3-bit priority.
- Holds the grant for the whole packet until the write datapath signals completion, then re-arbitrates.

---
 rtl/wr_arb_pkg.sv | 9 +
 rtl/wrr_sp_arbiter_if.sv | 26 ++
 rtl/rr_find_first.sv | 28 ++
 rtl/wrr_sp_arbiter.sv | 125 ++++++++++++
 tb/tb_wrr_sp_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/wr_arb_pkg.sv
// Shared constants for the SRAM write-port arbiter: FSM encoding, mode encoding
// and the default priority width.
package wr_arb_pkg;
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] BUSY      = 1'b1;
  localparam int         PRI_W_DEF = 3;
  localparam logic       MODE_SP   = 1'b0;
  localparam logic       MODE_WRR  = 1'b1;
endpackage

// File: rtl/wrr_sp_arbiter_if.sv
// Request/grant bundle between the ingress ports (master) and the write arbiter (slave).
interface wrr_sp_arbiter_if
  import wr_arb_pkg::*;
#(
  parameter int num_of_ports = 16,
  parameter int pri_w        = PRI_W_DEF,
  parameter int sel_w        = $clog2(num_of_ports)
);
  logic                            sp0_wrr1;
  logic [num_of_ports-1:0]         req;
  logic [num_of_ports*pri_w-1:0]   priority_in;
  logic                            done;
  logic                            grant_valid;
  logic [sel_w-1:0]                select;
  logic [num_of_ports-1:0]         grant_onehot;

  modport master (
    output sp0_wrr1, req, priority_in, done,
    input  grant_valid, select, grant_onehot
  );

  modport slave (
    input  sp0_wrr1, req, priority_in, done,
    output grant_valid, select, grant_onehot
  );
endinterface

// File: rtl/rr_find_first.sv
// Rotating priority encoder: first set bit of req searching start, start+1, ...
// with wrap modulo num_of_ports.
module rr_find_first #(
  parameter int num_of_ports = 16,
  parameter int sel_w        = $clog2(num_of_ports)
) (
  input  logic [num_of_ports-1:0] req,
  input  logic [sel_w-1:0]        start,
  output logic                    found,
  output logic [sel_w-1:0]        idx
);
  int unsigned      c;
  logic [sel_w-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found = |req;
    idx   = start;
    c     = 0;
    cand  = '0;
    for (int unsigned k = 0; k < num_of_ports; k++) begin
      c = 32'(start) + (num_of_ports - 1 - k);
      if (c >= num_of_ports) c = c - num_of_ports;
      cand = sel_w'(c);
      if (req[cand]) idx = cand;
    end
  end
endmodule

// File: rtl/wrr_sp_arbiter.sv
// Packet-granular write-port arbiter: strict priority or weighted round robin
// (weight = priority+1), grant held until the datapath pulses done.
module wrr_sp_arbiter
  import wr_arb_pkg::*;
#(
  parameter int num_of_ports = 16,
  parameter int pri_w        = PRI_W_DEF,
  parameter int sel_w        = $clog2(num_of_ports)
) (
  input  logic             clk,
  input  logic             rst_n,
  wrr_sp_arbiter_if.slave  bus
);
  logic [0:0]              state;
  logic                    grant_valid_q;
  logic [sel_w-1:0]        select_q;
  logic [num_of_ports-1:0] grant_onehot_q;
  logic [sel_w-1:0]        rr_ptr;
  logic [pri_w-1:0]        credit;
  logic                    last_mode;

  logic [pri_w-1:0]        pri_arr [num_of_ports];
  logic [sel_w-1:0]        rr_start;
  logic                    ff_found;
  logic [sel_w-1:0]        ff_idx;
  logic [pri_w-1:0]        credit_eff;
  logic                    arb_go;
  logic [sel_w-1:0]        win_sel;
  logic [num_of_ports-1:0] win_onehot;
  logic [sel_w-1:0]        nxt_rr;
  logic [pri_w-1:0]        nxt_credit;

  // SP reduction: each stage keeps the best (priority, index) seen so far;
  // strict '>' leaves ties with the lower index.
  for (genvar i = 0; i < num_of_ports; i++) begin : sp_stage
    logic             vld;
    logic [pri_w-1:0] best;
    logic [sel_w-1:0] idx;
    assign pri_arr[i] = bus.priority_in[i*pri_w +: pri_w];
    if (i == 0) begin : g_first
      assign vld  = bus.req[0];
      assign best = pri_arr[0];
      assign idx  = '0;
    end else begin : g_next
      logic take;
      assign take = bus.req[i] && (!sp_stage[i-1].vld || pri_arr[i] > sp_stage[i-1].best);
      assign vld  = sp_stage[i-1].vld || bus.req[i];
      assign best = take ? pri_arr[i] : sp_stage[i-1].best;
      assign idx  = take ? sel_w'(i) : sp_stage[i-1].idx;
    end
  end

  assign rr_start = (rr_ptr == sel_w'(num_of_ports - 1)) ? '0 : rr_ptr + 1'b1;

  rr_find_first #(
    .num_of_ports (num_of_ports),
    .sel_w        (sel_w)
  ) u_rr_find_first (
    .req   (bus.req),
    .start (rr_start),
    .found (ff_found),
    .idx   (ff_idx)
  );

  // A mode change discards any leftover WRR credit before this arbitration.
  assign credit_eff = (bus.sp0_wrr1 != last_mode) ? '0 : credit;

  always_comb begin
    arb_go     = sp_stage[num_of_ports-1].vld;
    win_sel    = sp_stage[num_of_ports-1].idx;
    nxt_rr     = rr_ptr;
    nxt_credit = '0;
    if (bus.sp0_wrr1 == MODE_WRR) begin
      arb_go = ff_found;
      if (bus.req[rr_ptr] && credit_eff != '0) begin
        win_sel    = rr_ptr;
        nxt_credit = credit_eff - 1'b1;
      end else begin
        win_sel    = ff_idx;
        nxt_rr     = ff_idx;
        nxt_credit = pri_arr[ff_idx];
      end
    end
    win_onehot          = '0;
    win_onehot[win_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      grant_valid_q  <= 1'b0;
      select_q       <= '0;
      grant_onehot_q <= '0;
      rr_ptr         <= sel_w'(num_of_ports - 1);
      credit         <= '0;
      last_mode      <= MODE_SP;
    end else begin
      case (state)
        IDLE: begin
          if (arb_go) begin
            state          <= BUSY;
            grant_valid_q  <= 1'b1;
            select_q       <= win_sel;
            grant_onehot_q <= win_onehot;
            rr_ptr         <= nxt_rr;
            credit         <= nxt_credit;
            last_mode      <= bus.sp0_wrr1;
          end
        end
        BUSY: begin
          if (bus.done) begin
            state          <= IDLE;
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant_valid  = grant_valid_q;
  assign bus.select       = select_q;
  assign bus.grant_onehot = grant_onehot_q;
endmodule

// File: tb/tb_wrr_sp_arbiter.sv
// Self-checking bench for wrr_sp_arbiter: vector table plus hand-written
// hold/reset/mode sequences, grants checked against a scoreboard queue.
module tb_wrr_sp_arbiter;
  import wr_arb_pkg::*;

  localparam int NP = 16;
  localparam int PW = 3;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [15:0] req;
    logic [47:0] pri;
    logic [3:0]  exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] sb [$];
  logic [3:0] mon_exp;
  logic       gv_prev = 1'b0;
  vec_t       vecs [23];

  wrr_sp_arbiter_if #(.num_of_ports(NP), .pri_w(PW)) bus ();

  wrr_sp_arbiter #(.num_of_ports(NP), .pri_w(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pr(input int a, input int va, input int b, input int vb,
                                     input int c, input int vc);
    logic [47:0] r;
    r = '0;
    if (a >= 0) r[a*3 +: 3] = 3'(va);
    if (b >= 0) r[b*3 +: 3] = 3'(vb);
    if (c >= 0) r[c*3 +: 3] = 3'(vc);
    return r;
  endfunction

  // Scoreboard side: every new grant pops the oldest expected port.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gv_prev = 1'b0;
      end else begin
        if (bus.grant_valid && !gv_prev) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant select=%0d with empty scoreboard", bus.select);
          end else begin
            mon_exp = sb.pop_front();
            if (bus.select !== mon_exp) begin
              errors++;
              $display("FAIL grant_select got %0d want %0d", bus.select, mon_exp);
            end
            checks++;
            if (bus.grant_onehot !== (16'h1 << mon_exp)) begin
              errors++;
              $display("FAIL grant_onehot got %h want %h", bus.grant_onehot, 16'h1 << mon_exp);
            end
          end
        end
        gv_prev = bus.grant_valid;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.select !== 4'd0 || bus.grant_onehot !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got gv=%b sel=%0d oh=%h want 0/0/0000",
               bus.grant_valid, bus.select, bus.grant_onehot);
    end
    rst_n = 1'b1;
  endtask

  // Called on a negedge; returns on the negedge where the grant is seen.
  task automatic request(input logic m, input logic [15:0] r, input logic [47:0] p,
                         input logic [3:0] e);
    logic got;
    bus.sp0_wrr1    = m;
    bus.req         = r;
    bus.priority_in = p;
    sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL grant_latency got gv=%b want 1 (port %0d)", bus.grant_valid, e);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        got = bus.grant_valid;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout got no grant want port %0d", e);
        if (sb.size() > 0) void'(sb.pop_back());
      end
    end
    bus.req = '0;
  endtask

  task automatic finish_pkt();
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 16'h0) begin
      errors++;
      $display("FAIL release got gv=%b oh=%h want 0/0000", bus.grant_valid, bus.grant_onehot);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sp0_wrr1    = MODE_SP;
    bus.req         = '0;
    bus.priority_in = '0;
    bus.done        = 1'b0;

    vecs[0]  = '{1'b1, MODE_SP,  16'h008A, pr(3, 5, 7, 5, 1, 2), 4'd3};
    vecs[1]  = '{1'b0, MODE_SP,  16'h0082, pr(3, 5, 7, 5, 1, 2), 4'd7};
    vecs[2]  = '{1'b0, MODE_SP,  16'h0002, pr(3, 5, 7, 5, 1, 2), 4'd1};
    vecs[3]  = '{1'b0, MODE_SP,  16'h8400, pr(-1, 0, -1, 0, -1, 0), 4'd10};
    vecs[4]  = '{1'b0, MODE_SP,  16'h8400, pr(15, 1, -1, 0, -1, 0), 4'd15};
    vecs[5]  = '{1'b1, MODE_WRR, 16'h0004, pr(2, 2, -1, 0, -1, 0), 4'd2};
    vecs[6]  = '{1'b0, MODE_WRR, 16'h0004, pr(2, 2, -1, 0, -1, 0), 4'd2};
    vecs[7]  = '{1'b0, MODE_WRR, 16'h0004, pr(2, 2, -1, 0, -1, 0), 4'd2};
    vecs[8]  = '{1'b0, MODE_WRR, 16'h0004, pr(2, 2, -1, 0, -1, 0), 4'd2};
    vecs[9]  = '{1'b1, MODE_WRR, 16'h0014, pr(2, 2, 4, 0, -1, 0), 4'd2};
    vecs[10] = '{1'b0, MODE_WRR, 16'h0014, pr(2, 2, 4, 0, -1, 0), 4'd2};
    vecs[11] = '{1'b0, MODE_WRR, 16'h0014, pr(2, 2, 4, 0, -1, 0), 4'd2};
    vecs[12] = '{1'b0, MODE_WRR, 16'h0014, pr(2, 2, 4, 0, -1, 0), 4'd4};
    vecs[13] = '{1'b0, MODE_WRR, 16'h0014, pr(2, 2, 4, 0, -1, 0), 4'd2};
    vecs[14] = '{1'b0, MODE_WRR, 16'h0014, pr(2, 2, 4, 0, -1, 0), 4'd2};
    vecs[15] = '{1'b0, MODE_WRR, 16'h0014, pr(2, 2, 4, 0, -1, 0), 4'd2};
    vecs[16] = '{1'b0, MODE_WRR, 16'h0014, pr(2, 2, 4, 0, -1, 0), 4'd4};
    vecs[17] = '{1'b1, MODE_WRR, 16'h8000, pr(-1, 0, -1, 0, -1, 0), 4'd15};
    vecs[18] = '{1'b0, MODE_WRR, 16'h4001, pr(-1, 0, -1, 0, -1, 0), 4'd0};
    vecs[19] = '{1'b0, MODE_WRR, 16'h4001, pr(-1, 0, -1, 0, -1, 0), 4'd14};
    vecs[20] = '{1'b1, MODE_WRR, 16'h0040, pr(6, 3, -1, 0, -1, 0), 4'd6};
    vecs[21] = '{1'b0, MODE_SP,  16'h0042, pr(1, 7, 6, 1, -1, 0), 4'd1};
    vecs[22] = '{1'b0, MODE_WRR, 16'h0144, pr(6, 3, -1, 0, -1, 0), 4'd8};

    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      request(vecs[k].mode, vecs[k].req, vecs[k].pri, vecs[k].exp);
      finish_pkt();
    end

    // Grant must ignore all input activity while BUSY.
    request(MODE_SP, 16'h0020, '0, 4'd5);
    for (int i = 0; i < 10; i++) begin
      bus.req         = 16'($urandom());
      bus.priority_in = 48'({$urandom(), $urandom()});
      bus.sp0_wrr1    = 1'($urandom());
      @(negedge clk);
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.select !== 4'd5 || bus.grant_onehot !== 16'h0020) begin
        errors++;
        $display("FAIL hold_cycle%0d got gv=%b sel=%0d oh=%h want 1/5/0020",
                 i, bus.grant_valid, bus.select, bus.grant_onehot);
      end
    end
    bus.req      = '0;
    bus.sp0_wrr1 = MODE_SP;
    finish_pkt();
    checks++;
    if (bus.select !== 4'd5) begin
      errors++;
      $display("FAIL select_after_done got %0d want 5", bus.select);
    end

    // done while idle has no effect.
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_done got gv=%b want 0", bus.grant_valid);
    end
    request(MODE_SP, 16'h0010, '0, 4'd4);
    finish_pkt();

    // Asynchronous reset while BUSY, then WRR search restarts at port 0.
    do_reset();
    request(MODE_WRR, 16'h1000, '0, 4'd12);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 16'h0) begin
      errors++;
      $display("FAIL async_reset got gv=%b oh=%h want 0/0000", bus.grant_valid, bus.grant_onehot);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    request(MODE_WRR, 16'h2200, '0, 4'd9);
    finish_pkt();

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
